// File: rtl/diff_if.sv
// Operand/result bundle for the ripple-borrow subtractor: the master side drives
// the operands, borrow-in and load enable; the slave side returns the results.
interface diff_if #(
   parameter int N = 8
);
   logic [N-1:0] x;
   logic [N-1:0] y;
   logic         b_in;
   logic         en;
   logic [N-1:0] d;
   logic         b_out;
   logic [N-1:0] d_r;
   logic         b_out_r;

   modport master (
      output x, y, b_in, en,
      input  d, b_out, d_r, b_out_r
   );

   modport slave (
      input  x, y, b_in, en,
      output d, b_out, d_r, b_out_r
   );
endinterface

// File: rtl/diff.sv
// N-bit unsigned ripple-borrow subtractor (x - y - b_in) with combinational
// results and an enabled, asynchronously reset output register.
module diff #(
   parameter int N = 8
) (
   input logic   clock,
   input logic   reset,
   diff_if.slave bus
);

   logic [N:0] sub_s;

   // Chain of full-subtractor cells; bit N of the result is the final borrow-out.
   function automatic logic [N:0] ripple_sub(
      input logic [N-1:0] a,
      input logic [N-1:0] b,
      input logic         bi
   );
      logic [N:0] r;
      logic       br;
      r  = '0;
      br = bi;
      for (int i = 0; i < N; i++) begin
         r[i] = a[i] ^ b[i] ^ br;
         br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
      end
      r[N] = br;
      return r;
   endfunction

   // Combinational difference and borrow, independent of clock, reset and en.
   always_comb begin
      sub_s = ripple_sub(bus.x, bus.y, bus.b_in);
   end

   assign bus.d     = sub_s[N-1:0];
   assign bus.b_out = sub_s[N];

   // Output register: cleared while reset is high, loads only when enabled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.d_r     <= '0;
         bus.b_out_r <= 1'b0;
      end else if (bus.en) begin
         bus.d_r     <= sub_s[N-1:0];
         bus.b_out_r <= sub_s[N];
      end
   end

endmodule

// File: tb/tb_diff.sv
// Directed bench for diff: reference vectors, exhaustive N=8 sweep, register
// control, asynchronous reset, N=1 cell and a chained 4+4 versus 8-bit check.
module tb_diff;

   logic clock;
   logic reset;
   int   errors;
   int   checks;

   diff_if #(.N(8)) dut_if ();
   diff_if #(.N(4)) lo_if ();
   diff_if #(.N(4)) hi_if ();
   diff_if #(.N(8)) w_if ();
   diff_if #(.N(1)) one_if ();

   diff #(.N(8)) u_dut (.clock(clock), .reset(reset), .bus(dut_if));
   diff #(.N(4)) u_lo  (.clock(clock), .reset(reset), .bus(lo_if));
   diff #(.N(4)) u_hi  (.clock(clock), .reset(reset), .bus(hi_if));
   diff #(.N(8)) u_w   (.clock(clock), .reset(reset), .bus(w_if));
   diff #(.N(1)) u_one (.clock(clock), .reset(reset), .bus(one_if));

   assign hi_if.b_in = lo_if.b_out;

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic bi);
      dut_if.x    = a;
      dut_if.y    = b;
      dut_if.b_in = bi;
      #1;
   endtask

   initial begin
      logic [8:0] e9;
      logic [7:0] sel;
      logic [7:0] rx, ry;
      logic       rb;
      logic [1:0] e2;
      errors = 0;
      checks = 0;
      clock  = 1'b0;
      reset  = 1'b1;
      dut_if.en = 1'b0;
      lo_if.en  = 1'b0;
      hi_if.en  = 1'b0;
      w_if.en   = 1'b0;
      one_if.en = 1'b0;
      lo_if.x = 4'd0; lo_if.y = 4'd0; lo_if.b_in = 1'b0;
      hi_if.x = 4'd0; hi_if.y = 4'd0;
      w_if.x  = 8'd0; w_if.y  = 8'd0; w_if.b_in = 1'b0;
      one_if.x = 1'b0; one_if.y = 1'b0; one_if.b_in = 1'b0;
      apply(8'h00, 8'h00, 1'b0);
      chk("reset_d_r", {24'd0, dut_if.d_r}, 32'h0);
      chk("reset_b_out_r", {31'd0, dut_if.b_out_r}, 32'h0);

      @(negedge clock);
      reset = 1'b0;

      // Basic vectors
      apply(8'h05, 8'h03, 1'b0);
      chk("5-3", {23'd0, dut_if.b_out, dut_if.d}, {23'd0, 1'b0, 8'h02});
      dut_if.en = 1'b1;
      @(posedge clock); #1;
      chk("5-3_reg", {23'd0, dut_if.b_out_r, dut_if.d_r}, {23'd0, 1'b0, 8'h02});
      apply(8'h03, 8'h05, 1'b0);
      chk("3-5", {23'd0, dut_if.b_out, dut_if.d}, {23'd0, 1'b1, 8'hFE});
      apply(8'h80, 8'h80, 1'b1);
      chk("eq_bin1", {23'd0, dut_if.b_out, dut_if.d}, {23'd0, 1'b1, 8'hFF});
      apply(8'h80, 8'h80, 1'b0);
      chk("eq_bin0", {23'd0, dut_if.b_out, dut_if.d}, {23'd0, 1'b0, 8'h00});
      apply(8'h00, 8'hFF, 1'b1);
      chk("0-ff-1", {23'd0, dut_if.b_out, dut_if.d}, {23'd0, 1'b1, 8'h00});
      apply(8'hFF, 8'h00, 1'b0);
      chk("ff-0", {23'd0, dut_if.b_out, dut_if.d}, {23'd0, 1'b0, 8'hFF});

      // Comparator use: pick x when b_out=1, else y
      apply(8'd7, 8'd9, 1'b0);
      sel = dut_if.b_out ? dut_if.x : dut_if.y;
      chk("min_7_9", {24'd0, sel}, 32'd7);
      apply(8'd9, 8'd7, 1'b0);
      sel = dut_if.b_out ? dut_if.x : dut_if.y;
      chk("min_9_7", {24'd0, sel}, 32'd7);
      apply(8'd4, 8'd4, 1'b0);
      sel = dut_if.b_out ? dut_if.x : dut_if.y;
      chk("min_4_4", {24'd0, sel}, 32'd4);
      apply(8'd0, 8'd255, 1'b0);
      sel = dut_if.b_out ? dut_if.x : dut_if.y;
      chk("min_0_255", {24'd0, sel}, 32'd0);

      // Register hold with en low
      @(negedge clock);
      dut_if.en = 1'b1;
      apply(8'h12, 8'h00, 1'b0);
      @(posedge clock); #1;
      chk("load_12", {24'd0, dut_if.d_r}, 32'h12);
      dut_if.en = 1'b0;
      apply(8'h34, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         chk("hold_d_r", {24'd0, dut_if.d_r}, 32'h12);
         chk("hold_d", {24'd0, dut_if.d}, 32'h34);
      end

      // Asynchronous reset mid-cycle
      @(negedge clock);
      dut_if.en = 1'b1;
      apply(8'h10, 8'h55, 1'b0);
      @(posedge clock); #1;
      chk("pre_rst", {23'd0, dut_if.b_out_r, dut_if.d_r}, {23'd0, 1'b1, 8'hBB});
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst", {23'd0, dut_if.b_out_r, dut_if.d_r}, 32'h0);
      chk("rst_comb", {23'd0, dut_if.b_out, dut_if.d}, {23'd0, 1'b1, 8'hBB});
      @(posedge clock); #1;
      chk("rst_hold", {23'd0, dut_if.b_out_r, dut_if.d_r}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      apply(8'h20, 8'h01, 1'b1);
      @(posedge clock); #1;
      chk("post_rst_load", {23'd0, dut_if.b_out_r, dut_if.d_r}, {23'd0, 1'b0, 8'h1E});
      dut_if.en = 1'b0;

      // Exhaustive sweep against reference equation
      for (int i = 0; i < 256; i++) begin
         for (int j = 0; j < 256; j++) begin
            for (int k = 0; k < 2; k++) begin
               apply(i[7:0], j[7:0], k[0]);
               e9 = {1'b0, i[7:0]} - {1'b0, j[7:0]} - {8'd0, k[0]};
               chk("sweep", {23'd0, dut_if.b_out, dut_if.d}, {23'd0, e9});
            end
         end
      end

      // N=1 single cell
      for (int i = 0; i < 8; i++) begin
         one_if.x    = i[2];
         one_if.y    = i[1];
         one_if.b_in = i[0];
         #1;
         e2 = {1'b0, i[2]} - {1'b0, i[1]} - {1'b0, i[0]};
         chk("n1", {30'd0, one_if.b_out, one_if.d}, {30'd0, e2});
      end

      // Chained 4+4 against a single 8-bit instance and the reference
      for (int t = 0; t < 1000; t++) begin
         rx = 8'($urandom_range(0, 255));
         ry = 8'($urandom_range(0, 255));
         rb = 1'($urandom_range(0, 1));
         lo_if.x = rx[3:0]; lo_if.y = ry[3:0]; lo_if.b_in = rb;
         hi_if.x = rx[7:4]; hi_if.y = ry[7:4];
         w_if.x  = rx;      w_if.y  = ry;      w_if.b_in  = rb;
         #1;
         e9 = {1'b0, rx} - {1'b0, ry} - {8'd0, rb};
         chk("chain_vs_wide", {23'd0, hi_if.b_out, hi_if.d, lo_if.d}, {23'd0, w_if.b_out, w_if.d});
         chk("chain_vs_ref", {23'd0, hi_if.b_out, hi_if.d, lo_if.d}, {23'd0, e9});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
